// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war key front end.
// The move code carries one-cycle press pulses: [1] = left player, [0] = right player.
package tow_pkg;

    typedef logic [1:0] move_t;

    localparam move_t MOVE_NONE = 2'b00;
    localparam move_t MOVE_R    = 2'b01;
    localparam move_t MOVE_L    = 2'b10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } key_state_e;

    // Simultaneous presses cancel; game over swallows everything.
    function automatic move_t encode_move(input logic pl, input logic pr, input logic go);
        move_t m;
        m = MOVE_NONE;
        if (go) begin
            m = MOVE_NONE;
        end else begin
            m = {pl & ~pr, pr & ~pl};
        end
        return m;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: 2-FF synchroniser, press/release debounce FSM with a
// saturating counter, and a single-cycle press pulse on an accepted press.
module key_debouncer
    import tow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             sync1_q;
    logic             sync2_q;
    logic             k_s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign k_s = sync2_q;

    // Synchroniser on the inverted key so that 1 means pressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
        end
    end

    // State and debounce counter registers; HELD at reset forces a clean release first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HELD;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and pulse decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (k_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            PRESS_WAIT: begin
                if (!k_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    state_d     = HELD;
                    cnt_d       = CNT_ZERO;
                    press_pulse = 1'b1;
                end
            end
            HELD: begin
                if (!k_s) begin
                    state_d = REL_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            REL_WAIT: begin
                if (k_s) begin
                    state_d = HELD;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = HELD;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/player_move_encoder.sv
// Tug-of-war front end: two debounced keys combined into a registered
// one-cycle move code, with press cancellation and game-over suppression.
module player_move_encoder
    import tow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_l_n,
    input  logic       key_r_n,
    input  logic       game_over,
    output logic [1:0] move
);

    logic  pulse_l_s;
    logic  pulse_r_s;
    move_t move_q, move_d;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_l (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_l_n),
        .press_pulse (pulse_l_s)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_r (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_r_n),
        .press_pulse (pulse_r_s)
    );

    // Move code for the coming cycle.
    always_comb begin
        move_d = MOVE_NONE;
        move_d = encode_move(pulse_l_s, pulse_r_s, game_over);
    end

    // Move output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            move_q <= MOVE_NONE;
        end else begin
            move_q <= move_d;
        end
    end

    assign move = move_q;

endmodule

// File: tb/tb_player_move_encoder.sv
// Bench for player_move_encoder: directed scenarios plus random key/game-over
// traffic, all checked against a run-length debounce reference model.
module tb_player_move_encoder;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic       key_l_n;
    logic       key_r_n;
    logic       game_over;
    logic [1:0] move;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no;

    player_move_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_l_n   (key_l_n),
        .key_r_n   (key_r_n),
        .game_over (game_over),
        .move      (move)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a key's accepted level flips once D+1 consecutive synced
    // samples disagree with it; a flip to "pressed" is a press pulse.
    logic [1:0] hist_l, hist_r;
    logic       acc_l, acc_r;
    int         run_l, run_r;
    logic [1:0] exp_move;
    logic       press_l, press_r;

    function automatic logic flips(input logic acc, input int run, input logic k);
        return (k != acc) && (run == D);
    endfunction

    function automatic int next_run(input logic acc, input int run, input logic k);
        if (k == acc) return 0;
        if (run == D) return 0;
        return run + 1;
    endfunction

    assign press_l = flips(acc_l, run_l, hist_l[1]) && hist_l[1];
    assign press_r = flips(acc_r, run_r, hist_r[1]) && hist_r[1];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_l   <= 2'b00;
            hist_r   <= 2'b00;
            acc_l    <= 1'b1;
            acc_r    <= 1'b1;
            run_l    <= 0;
            run_r    <= 0;
            exp_move <= 2'b00;
            edge_no  <= 0;
        end else begin
            hist_l   <= {hist_l[0], ~key_l_n};
            hist_r   <= {hist_r[0], ~key_r_n};
            acc_l    <= flips(acc_l, run_l, hist_l[1]) ? hist_l[1] : acc_l;
            acc_r    <= flips(acc_r, run_r, hist_r[1]) ? hist_r[1] : acc_r;
            run_l    <= next_run(acc_l, run_l, hist_l[1]);
            run_r    <= next_run(acc_r, run_r, hist_r[1]);
            exp_move <= game_over ? 2'b00 : {press_l & ~press_r, press_r & ~press_l};
            edge_no  <= edge_no + 1;
        end
    end

    // Advance n cycles, tallying model divergences and nonzero moves.
    task automatic run_cycles(input int n, output int mism, output int hits,
                              output int hit_edge, output logic [1:0] hit_val);
        mism = 0; hits = 0; hit_edge = -1; hit_val = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (move !== exp_move) mism++;
            if (move !== 2'b00) begin
                hits++;
                hit_edge = edge_no;
                hit_val  = move;
            end
        end
    endtask

    task automatic test_reset();
        int m, h, he; logic [1:0] hv;
        reset = 1'b1; key_l_n = 1'b1; key_r_n = 1'b1; game_over = 1'b0;
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (move !== 2'b00) begin n_fail++; $display("FAIL reset_move: got %b want 00", move); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        run_cycles(20, m, h, he, hv);
        n_tests++;
        if (m !== 0) begin n_fail++; $display("FAIL idle_model: %0d divergent cycles, want 0", m); end
        n_tests++;
        if (h !== 0) begin n_fail++; $display("FAIL idle_quiet: %0d nonzero moves, want 0", h); end
    endtask

    task automatic test_press_l();
        int m, h, he, st, m2, h2; logic [1:0] hv;
        key_l_n = 1'b0; st = edge_no;
        run_cycles(12, m, h, he, hv);
        n_tests++;
        if (m !== 0) begin n_fail++; $display("FAIL press_l_model: %0d divergent, want 0", m); end
        n_tests++;
        if (h !== 1) begin n_fail++; $display("FAIL press_l_count: %0d pulses, want 1", h); end
        n_tests++;
        if (he !== st + D + 3) begin n_fail++; $display("FAIL press_l_latency: edge %0d, want %0d", he, st + D + 3); end
        n_tests++;
        if (hv !== 2'b10) begin n_fail++; $display("FAIL press_l_value: got %b want 10", hv); end
        key_l_n = 1'b1;
        run_cycles(10, m2, h2, he, hv);
        n_tests++;
        if (m2 !== 0 || h2 !== 0) begin n_fail++; $display("FAIL release_l: divergent %0d pulses %0d, want 0/0", m2, h2); end
    endtask

    task automatic test_bounce_r();
        int m1, m2, m3, h1, h2, h3, he, st; logic [1:0] hv;
        key_r_n = 1'b0;
        run_cycles(2, m1, h1, he, hv);
        key_r_n = 1'b1;
        run_cycles(1, m2, h2, he, hv);
        key_r_n = 1'b0; st = edge_no;
        run_cycles(12, m3, h3, he, hv);
        n_tests++;
        if (m1 + m2 + m3 !== 0) begin n_fail++; $display("FAIL bounce_model: %0d divergent, want 0", m1 + m2 + m3); end
        n_tests++;
        if (h1 + h2 + h3 !== 1) begin n_fail++; $display("FAIL bounce_count: %0d pulses, want 1", h1 + h2 + h3); end
        n_tests++;
        if (he !== st + D + 3 || hv !== 2'b01) begin n_fail++; $display("FAIL bounce_pulse: edge %0d val %b, want %0d 01", he, hv, st + D + 3); end
        key_r_n = 1'b1;
        run_cycles(10, m1, h1, he, hv);
    endtask

    task automatic test_both();
        int m, h, he, st, m2, h2; logic [1:0] hv;
        key_l_n = 1'b0; key_r_n = 1'b0;
        run_cycles(12, m, h, he, hv);
        n_tests++;
        if (m !== 0 || h !== 0) begin n_fail++; $display("FAIL both_cancel: divergent %0d pulses %0d, want 0/0", m, h); end
        key_l_n = 1'b1; key_r_n = 1'b1;
        run_cycles(8, m2, h2, he, hv);
        key_r_n = 1'b0; st = edge_no;
        run_cycles(12, m, h, he, hv);
        n_tests++;
        if (m + m2 !== 0 || h2 !== 0) begin n_fail++; $display("FAIL both_after_model: divergent %0d pulses %0d, want 0/0", m + m2, h2); end
        n_tests++;
        if (h !== 1 || hv !== 2'b01 || he !== st + D + 3) begin
            n_fail++; $display("FAIL both_then_r: %0d pulses val %b edge %0d, want 1 01 %0d", h, hv, he, st + D + 3);
        end
    endtask

    task automatic test_back_to_back();
        int m, h, he, st; logic [1:0] hv;
        key_l_n = 1'b0; st = edge_no;
        run_cycles(12, m, h, he, hv);
        n_tests++;
        if (m !== 0) begin n_fail++; $display("FAIL held_other_model: %0d divergent, want 0", m); end
        n_tests++;
        if (h !== 1 || hv !== 2'b10 || he !== st + D + 3) begin
            n_fail++; $display("FAIL held_other_pulse: %0d pulses val %b edge %0d, want 1 10 %0d", h, hv, he, st + D + 3);
        end
        key_l_n = 1'b1; key_r_n = 1'b1;
        run_cycles(10, m, h, he, hv);
    endtask

    task automatic test_game_over();
        int m1, m2, m3, m4, h1, h2, h3, h4, he, st; logic [1:0] hv;
        game_over = 1'b1;
        run_cycles(2, m1, h1, he, hv);
        key_l_n = 1'b0;
        run_cycles(10, m2, h2, he, hv);
        game_over = 1'b0;
        run_cycles(10, m3, h3, he, hv);
        n_tests++;
        if (m1 + m2 + m3 !== 0 || h1 + h2 + h3 !== 0) begin
            n_fail++; $display("FAIL game_over_block: divergent %0d pulses %0d, want 0/0", m1 + m2 + m3, h1 + h2 + h3);
        end
        key_l_n = 1'b1;
        run_cycles(8, m4, h4, he, hv);
        key_l_n = 1'b0; st = edge_no;
        run_cycles(12, m4, h4, he, hv);
        n_tests++;
        if (m4 !== 0 || h4 !== 1 || hv !== 2'b10 || he !== st + D + 3) begin
            n_fail++; $display("FAIL game_over_repress: div %0d pulses %0d val %b edge %0d, want 0 1 10 %0d", m4, h4, hv, he, st + D + 3);
        end
        key_l_n = 1'b1;
        run_cycles(10, m4, h4, he, hv);
    endtask

    task automatic test_reset_held();
        int m, h, he, st; logic [1:0] hv;
        key_l_n = 1'b0;
        run_cycles(D + 3, m, h, he, hv);
        n_tests++;
        if (move !== 2'b10) begin n_fail++; $display("FAIL pre_reset_pulse: got %b want 10", move); end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (move !== 2'b00) begin n_fail++; $display("FAIL async_reset_drop: got %b want 00", move); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_cycles(12, m, h, he, hv);
        n_tests++;
        if (m !== 0 || h !== 0) begin n_fail++; $display("FAIL held_through_reset: divergent %0d pulses %0d, want 0/0", m, h); end
        key_l_n = 1'b1;
        run_cycles(6, m, h, he, hv);
        key_l_n = 1'b0; st = edge_no;
        run_cycles(12, m, h, he, hv);
        n_tests++;
        if (h !== 1 || hv !== 2'b10 || he !== st + D + 3) begin
            n_fail++; $display("FAIL post_reset_press: %0d pulses val %b edge %0d, want 1 10 %0d", h, hv, he, st + D + 3);
        end
        key_l_n = 1'b1;
        run_cycles(10, m, h, he, hv);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_tests++;
            if (move !== exp_move) begin
                n_fail++; $display("FAIL random_cycle: edge %0d got %b want %b", edge_no, move, exp_move);
            end
            if ($urandom_range(0, 15) == 0) key_l_n = ~key_l_n;
            if ($urandom_range(0, 15) == 0) key_r_n = ~key_r_n;
            if ($urandom_range(0, 63) == 0) game_over = ~game_over;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                #1;
                n_tests++;
                if (move !== 2'b00) begin n_fail++; $display("FAIL random_reset: got %b want 00", move); end
                @(negedge clk);
                reset = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_l();
        test_bounce_r();
        test_both();
        test_back_to_back();
        test_game_over();
        test_reset_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
